// File: rtl/shift_seq_pkg.sv
// Shared types for the sequential bit-serial shifter.
// Holds the shift opcode, the FSM state encoding and small counter helpers.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // amt == 0 still costs one pass through RUN, so the step count is never zero.
    function automatic int unsigned step_count(input int unsigned amt);
        return (amt == 0) ? 1 : amt;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step applied once per RUN cycle.
// SHIFT_SEQ_ROTATE_EN turns SH_NONE into a rotate-right by one bit.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_operand,
    input  shift_op_t        i_op,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = i_operand;
        unique case (i_op)
`ifdef SHIFT_SEQ_ROTATE_EN
            SH_NONE: o_result = {i_operand[0], i_operand[WIDTH-1:1]};
`else
            SH_NONE: o_result = i_operand;
`endif
            SH_LSL:  o_result = {i_operand[WIDTH-2:0], 1'b0};
            SH_LSR:  o_result = {1'b0, i_operand[WIDTH-1:1]};
            SH_ASR:  o_result = {i_operand[WIDTH-1], i_operand[WIDTH-1:1]};
            default: o_result = i_operand;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: one bit position per cycle, IDLE -> RUN -> DONE handshake FSM.
// Optional SHIFT_SEQ_ROTATE_EN makes op 00 rotate right instead of passing through.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             zflag,
    output logic             nflag
);

    if ((2 ** AMT_W) < WIDTH) begin : g_bad_amt_w
        $error("shift_seq: AMT_W too small to express every bit position of WIDTH");
    end

    state_e           r_state, w_state_nxt;
    logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    shift_op_t        r_op, w_op_nxt;
    logic             r_hold, w_hold_nxt;
    logic             r_zflag, w_zflag_nxt;
    logic             r_nflag, w_nflag_nxt;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_run_result;
    logic             w_last_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_operand (r_work),
        .i_op      (r_op),
        .o_result  (w_step)
    );

    // r_hold marks an amt == 0 request: it spends its single RUN cycle without stepping.
    assign w_run_result = r_hold ? r_work : w_step;
    assign w_last_step  = (r_cnt == AMT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        w_op_nxt    = r_op;
        w_hold_nxt  = r_hold;
        w_zflag_nxt = r_zflag;
        w_nflag_nxt = r_nflag;

        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = AMT_W'(step_count(int'(amt)));
                    w_work_nxt  = in;
                    w_op_nxt    = shift_op_t'(shift);
                    w_hold_nxt  = (amt == '0);
                    w_zflag_nxt = 1'b0;
                    w_nflag_nxt = 1'b0;
                end
            end
            StRun: begin
                w_work_nxt = w_run_result;
                w_cnt_nxt  = r_cnt - AMT_W'(1);
                if (w_last_step) begin
                    w_state_nxt = StDone;
                    w_zflag_nxt = (w_run_result == '0);
                    w_nflag_nxt = w_run_result[WIDTH-1];
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_work  <= '0;
            r_op    <= SH_NONE;
            r_hold  <= 1'b0;
            r_zflag <= 1'b0;
            r_nflag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
            r_op    <= w_op_nxt;
            r_hold  <= w_hold_nxt;
            r_zflag <= w_zflag_nxt;
            r_nflag <= w_nflag_nxt;
        end
    end

    assign in_ready  = (r_state == StIdle) && rst_n;
    assign out_valid = (r_state == StDone);
    assign sout      = r_work;
    assign zflag     = r_zflag;
    assign nflag     = r_nflag;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus random requests vs a reference model.
// Honours SHIFT_SEQ_ROTATE_EN when the model decides what op 00 produces.
module tb_shift_seq;

    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    shift;
    logic [AW-1:0] amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sout;
    logic          zflag;
    logic          nflag;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq #(
        .WIDTH (W),
        .AMT_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .shift     (shift),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sout      (sout),
        .zflag     (zflag),
        .nflag     (nflag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-shift result computed directly from the operation, not step by step.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [1:0] op,
                                           input int n);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   res;
        dbl = {a, a};
        case (op)
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b00: begin
                dbl = dbl >> (n % W);
                res = dbl[W-1:0];
            end
`else
            2'b00: res = a;
`endif
            2'b01: res = a << n;
            2'b10: res = a >> n;
            default: res = W'($signed(a) >>> n);
        endcase
        return res;
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_req(input logic [W-1:0] a, input logic [1:0] op, input logic [AW-1:0] n,
                           input int hold, input string tag);
        int           cyc;
        int           guard;
        int           bad;
        logic [W-1:0] exp;
        exp      = model(a, op, int'(n));
        in_data  = a;
        shift    = op;
        amt      = n;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        shift    = 2'($urandom);
        amt      = AW'($urandom);
        check({tag, " busy"}, 32'(in_ready), 32'd0);
        wait_valid(cyc);
        check({tag, " latency"}, 32'(cyc), 32'((n == 0) ? 1 : n));
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " sout"}, 32'(sout), 32'(exp));
        check({tag, " zflag"}, 32'(zflag), 32'(exp == '0));
        check({tag, " nflag"}, 32'(nflag), 32'(exp[W-1]));
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (sout !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            end
            check({tag, " hold"}, 32'(bad), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int           cyc;
        int           bad;
        logic [W-1:0] ra;
        logic [1:0]   rop;
        logic [AW-1:0] rn;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        shift     = 2'b00;
        amt       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sout", 32'(sout), 32'd0);
        check("rst zflag", 32'(zflag), 32'd0);
        check("rst nflag", 32'(nflag), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        run_req(16'h8001, 2'b01, 4'd1, 0, "lsl1");
        run_req(16'h8000, 2'b11, 4'd15, 0, "asr15");
        run_req(16'h00F0, 2'b10, 4'd0, 5, "lsr0_hold");
        run_req(16'h0003, 2'b00, 4'd1, 0, "op00_amt1");
        run_req(16'h8421, 2'b00, 4'd0, 0, "op00_amt0");
        run_req(16'hFFFF, 2'b01, 4'd15, 1, "lsl15");

        // in_valid held high across a handshake: no accept on the out_ready edge.
        in_data  = 16'h0001;
        shift    = 2'b10;
        amt      = 4'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first accepted", 32'(in_ready), 32'd0);
        in_data = 16'h1234;
        shift   = 2'b01;
        amt     = 4'd2;
        wait_valid(cyc);
        check("b2b latency", 32'(cyc), 32'd4);
        check("b2b sout", 32'(sout), 32'h0000);
        check("b2b zflag", 32'(zflag), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b no same-edge accept", 32'(in_ready), 32'd1);
        check("b2b out_valid low", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b second accepted", 32'(in_ready), 32'd0);
        wait_valid(cyc);
        check("b2b second latency", 32'(cyc), 32'd2);
        check("b2b second sout", 32'(sout), 32'(model(16'h1234, 2'b01, 2)));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into a long request abandons it.
        in_data  = 16'h00FF;
        shift    = 2'b01;
        amt      = 4'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun rst in_ready", 32'(in_ready), 32'd0);
        check("midrun rst sout", 32'(sout), 32'd0);
        check("midrun rst out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midrun release in_ready", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        check("midrun no result", 32'(bad), 32'd0);

        for (int k = 0; k < 30; k++) begin
            ra  = W'($urandom);
            rop = 2'($urandom);
            rn  = AW'($urandom);
            run_req(ra, rop, rn, int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
